// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame deserializer slice.
// The sync pattern itself is matched upstream; this package only records it.
package serial_frame_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int SYNC_LEN = 6;
    localparam logic [SYNC_LEN-1:0] SYNC_PATTERN = 6'b110011;

endpackage

// File: rtl/out_word_buf.sv
// Single-entry valid/ready holding register.
// A word that arrives while the held word is still waiting is dropped; drops are counted with saturation.
module out_word_buf #(
    parameter int WORD_W     = 8,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WORD_W-1:0]     load_data,
    input  logic                  ready,
    output logic [WORD_W-1:0]     data,
    output logic                  valid,
    output logic                  drop,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam logic [DROP_CNT_W-1:0] CNT_MAX = {DROP_CNT_W{1'b1}};

    logic [WORD_W-1:0]     data_r;
    logic                  valid_r;
    logic                  drop_r;
    logic [DROP_CNT_W-1:0] drop_count_r;

    // Holding register, handshake and drop accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r       <= {WORD_W{1'b0}};
            valid_r      <= 1'b0;
            drop_r       <= 1'b0;
            drop_count_r <= {DROP_CNT_W{1'b0}};
        end else begin
            drop_r <= 1'b0;
            if (load) begin
                // A same-cycle transfer frees the slot, so the new word is accepted.
                if (!valid_r || ready) begin
                    data_r  <= load_data;
                    valid_r <= 1'b1;
                end else begin
                    drop_r <= 1'b1;
                    if (drop_count_r != CNT_MAX) begin
                        drop_count_r <= drop_count_r + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        drop_count_r <= drop_count_r;
                    end
                end
            end else if (valid_r && ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign data       = data_r;
    assign valid      = valid_r;
    assign drop       = drop_r;
    assign drop_count = drop_count_r;

endmodule

// File: rtl/serial_frame_deserializer.sv
// Captures PAYLOAD_W serial bits after each sync hit and presents them as a parallel word.
// Optional build macro: SERIAL_FRAME_DESERIALIZER_RESYNC_EN (a detector hit mid-frame restarts collection).
module serial_frame_deserializer
    import serial_frame_pkg::*;
#(
    parameter int PAYLOAD_W  = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  new_bit,
    input  logic                  detected,
    output logic [PAYLOAD_W-1:0]  payload_data,
    output logic                  payload_valid,
    input  logic                  payload_ready,
    output logic                  frame_drop,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic                  busy
);

    localparam int CNT_W = (PAYLOAD_W > 2) ? $clog2(PAYLOAD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [PAYLOAD_W-1:0] shift_r;
    logic [PAYLOAD_W-1:0] shift_next_s;
    logic                 busy_r;
    logic                 last_bit_s;
    logic                 restart_s;

    // Next shift-register value with the current serial bit folded in.
    always_comb begin
        shift_next_s = shift_r;
        if (MSB_FIRST) begin
            shift_next_s = {shift_r[PAYLOAD_W-2:0], new_bit};
        end else begin
            shift_next_s = {new_bit, shift_r[PAYLOAD_W-1:1]};
        end
    end

    assign last_bit_s = (state_r == COLLECT) && (cnt_r == LAST_IDX);

`ifdef SERIAL_FRAME_DESERIALIZER_RESYNC_EN
    assign restart_s = detected && !last_bit_s;
`else
    assign restart_s = 1'b0;
`endif

    // Hunt/collect sequencer with bit counter and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= HUNT;
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {PAYLOAD_W{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                HUNT: begin
                    if (detected) begin
                        shift_r <= shift_next_s;
                        cnt_r   <= CNT_ONE;
                        state_r <= COLLECT;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= HUNT;
                        busy_r  <= 1'b0;
                    end
                end
                COLLECT: begin
                    shift_r <= shift_next_s;
                    // The completion cycle never honours detected; a new frame needs a fresh hit in HUNT.
                    if (last_bit_s) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= HUNT;
                        busy_r  <= 1'b0;
                    end else if (restart_s) begin
                        cnt_r   <= CNT_ONE;
                        state_r <= COLLECT;
                        busy_r  <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        state_r <= COLLECT;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= HUNT;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;

    out_word_buf #(
        .WORD_W     (PAYLOAD_W),
        .DROP_CNT_W (DROP_CNT_W)
    ) u_out_word_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (last_bit_s),
        .load_data  (shift_next_s),
        .ready      (payload_ready),
        .data       (payload_data),
        .valid      (payload_valid),
        .drop       (frame_drop),
        .drop_count (drop_count)
    );

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench: three deserializer builds (MSB-first, LSB-first, 2-bit drop counter) share one stream.
module tb_serial_frame_deserializer;
    import serial_frame_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_bit = 1'b0;
    logic       detected = 1'b0;
    logic       ready = 1'b1;

    logic [7:0] a_data, b_data, c_data;
    logic       a_valid, b_valid, c_valid;
    logic       a_drop, b_drop, c_drop;
    logic [7:0] a_cnt, b_cnt;
    logic [1:0] c_cnt;
    logic       a_busy, b_busy, c_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_frame_deserializer #(.PAYLOAD_W(8), .MSB_FIRST(1'b1), .DROP_CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .new_bit(new_bit), .detected(detected),
        .payload_data(a_data), .payload_valid(a_valid), .payload_ready(ready),
        .frame_drop(a_drop), .drop_count(a_cnt), .busy(a_busy));

    serial_frame_deserializer #(.PAYLOAD_W(8), .MSB_FIRST(1'b0), .DROP_CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .new_bit(new_bit), .detected(detected),
        .payload_data(b_data), .payload_valid(b_valid), .payload_ready(ready),
        .frame_drop(b_drop), .drop_count(b_cnt), .busy(b_busy));

    serial_frame_deserializer #(.PAYLOAD_W(8), .MSB_FIRST(1'b1), .DROP_CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .new_bit(new_bit), .detected(detected),
        .payload_data(c_data), .payload_valid(c_valid), .payload_ready(ready),
        .frame_drop(c_drop), .drop_count(c_cnt), .busy(c_busy));

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic b, input logic d);
        new_bit  = b;
        detected = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_sync();
        logic [5:0] pat;
        pat = SYNC_PATTERN;
        for (int i = 5; i >= 0; i--) step(pat[i], 1'b0);
    endtask

    // Payload bit 0 is p[7]; detected accompanies bit 0 and optionally bit pulse_idx.
    task automatic send_payload(input logic [7:0] p, input int pulse_idx);
        for (int i = 0; i < 8; i++) step(p[7-i], (i == 0) || (i == pulse_idx));
    endtask

    initial begin
        logic [7:0] p;
        logic [1:0] c_exp;

        // Reset state
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_value("rst_valid", {31'd0, a_valid}, 32'd0);
        check_value("rst_data", {24'd0, a_data}, 32'd0);
        check_value("rst_busy", {31'd0, a_busy}, 32'd0);
        check_value("rst_drop", {31'd0, a_drop}, 32'd0);
        check_value("rst_cnt", {24'd0, a_cnt}, 32'd0);
        rst = 1'b0;

        // 1: basic MSB-first capture, ready high
        ready = 1'b1;
        send_sync();
        p = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            step(p[7-i], i == 0);
            if (i < 7) begin
                check_value($sformatf("t1_busy_b%0d", i), {31'd0, a_busy}, 32'd1);
                check_value($sformatf("t1_valid_b%0d", i), {31'd0, a_valid}, 32'd0);
            end else begin
                check_value("t1_busy_done", {31'd0, a_busy}, 32'd0);
                check_value("t1_valid", {31'd0, a_valid}, 32'd1);
                check_value("t1_data", {24'd0, a_data}, 32'hA5);
                check_value("t2_data_lsb_a5", {24'd0, b_data}, 32'hA5);
            end
        end
        step(1'b0, 1'b0);
        check_value("t1_valid_one_cycle", {31'd0, a_valid}, 32'd0);

        // 2: LSB-first reverses the word
        send_sync();
        send_payload(8'hF0, -1);
        check_value("t2_b_valid", {31'd0, b_valid}, 32'd1);
        check_value("t2_b_data", {24'd0, b_data}, 32'h0F);
        check_value("t2_a_data", {24'd0, a_data}, 32'hF0);
        step(1'b0, 1'b0);
        check_value("t2_b_valid_clr", {31'd0, b_valid}, 32'd0);

        // 3: backpressure drops the second frame
        ready = 1'b0;
        send_sync();
        send_payload(8'h3C, -1);
        check_value("t3_valid1", {31'd0, a_valid}, 32'd1);
        check_value("t3_data1", {24'd0, a_data}, 32'h3C);
        check_value("t3_nodrop1", {31'd0, a_drop}, 32'd0);
        send_sync();
        send_payload(8'hC3, -1);
        check_value("t3_drop", {31'd0, a_drop}, 32'd1);
        check_value("t3_cnt", {24'd0, a_cnt}, 32'd1);
        check_value("t3_data_held", {24'd0, a_data}, 32'h3C);
        step(1'b0, 1'b0);
        check_value("t3_drop_pulse", {31'd0, a_drop}, 32'd0);
        check_value("t3_valid_held", {31'd0, a_valid}, 32'd1);
        ready = 1'b1;
        step(1'b0, 1'b0);
        check_value("t3_xfer", {31'd0, a_valid}, 32'd0);

        // 4: detector hit inside the payload
        send_sync();
        send_payload(8'hCC, 6);
`ifdef SERIAL_FRAME_DESERIALIZER_RESYNC_EN
        check_value("t4_restart_valid", {31'd0, a_valid}, 32'd0);
        check_value("t4_restart_busy", {31'd0, a_busy}, 32'd1);
        p = 8'h15;
        for (int i = 2; i < 8; i++) step(p[7-i], 1'b0);
        check_value("t4_restart_data", {24'd0, a_data}, 32'h15);
`else
        check_value("t4_valid", {31'd0, a_valid}, 32'd1);
        check_value("t4_data", {24'd0, a_data}, 32'hCC);
        check_value("t4_busy", {31'd0, a_busy}, 32'd0);
`endif
        step(1'b0, 1'b0);

        // 5: reset in the middle of a collection
        send_sync();
        p = 8'hFF;
        for (int i = 0; i < 4; i++) step(p[7-i], i == 0);
        rst = 1'b1;
        step(1'b1, 1'b0);
        rst = 1'b0;
        check_value("t5_busy", {31'd0, a_busy}, 32'd0);
        check_value("t5_valid", {31'd0, a_valid}, 32'd0);
        check_value("t5_data", {24'd0, a_data}, 32'd0);
        check_value("t5_cnt", {24'd0, a_cnt}, 32'd0);
        check_value("t5_drop", {31'd0, a_drop}, 32'd0);
        send_sync();
        send_payload(8'h5A, -1);
        check_value("t5_valid_after", {31'd0, a_valid}, 32'd1);
        check_value("t5_data_after", {24'd0, a_data}, 32'h5A);
        check_value("t5_b_data_after", {24'd0, b_data}, 32'h5A);
        step(1'b0, 1'b0);

        // 6: drop counter saturation with a 2-bit counter
        ready = 1'b0;
        for (int f = 0; f < 6; f++) begin
            send_sync();
            send_payload(8'h96 ^ 8'(f), -1);
            if (f == 0) begin
                check_value("t6_first_valid", {31'd0, c_valid}, 32'd1);
                check_value("t6_first_nodrop", {31'd0, c_drop}, 32'd0);
            end else begin
                c_exp = (f > 3) ? 2'd3 : 2'(f);
                check_value($sformatf("t6_drop_f%0d", f), {31'd0, c_drop}, 32'd1);
                check_value($sformatf("t6_ccnt_f%0d", f), {30'd0, c_cnt}, {30'd0, c_exp});
                check_value($sformatf("t6_acnt_f%0d", f), {24'd0, a_cnt}, f);
            end
        end
        check_value("t6_data_held", {24'd0, c_data}, 32'h96);
        ready = 1'b1;
        step(1'b0, 1'b0);
        check_value("t6_xfer", {31'd0, c_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
